rx: RTL and testbench
=====================

# rx

Serial receiver for the RS232 DCE port. It is the receive-side counterpart of the existing transmitter and uses the same line format: 9600 baud from the 50 MHz clock, 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. The block synchronises the RXD pin, validates the start bit, and samples each bit at mid-period. It presents each good byte as a one-cycle valid pulse with held data, and mirrors the last good byte on the board LEDs.

## Interface
Parameters:
- CLKS_PER_BIT, default 5209: CLK_50M cycles per bit. This equals the transmitter's bit period (divider count 0..5208).
- HALF_BIT, default 2604: cycles from the start-bit edge to its mid-point; equals CLKS_PER_BIT/2, rounded down.

Ports:
- CLK_50M, in, 1: the single clock. All logic is on its rising edge.
- BTN_SOUTH, in, 1: asynchronous, active-high reset. It clears all state immediately.
- RS232_DCE_RXD, in, 1: asynchronous serial input; the line idles high.
- rx_data, out, 8: last byte received with a good stop bit. Held until the next good byte.
- rx_valid, out, 1: one-cycle pulse when rx_data updates.
- rx_frame_err, out, 1: one-cycle pulse when the stop bit is sampled low.
- LED, out, 8: registered copy of rx_data.

## Operation
- Synchroniser: two flops on RS232_DCE_RXD, both reset to 1. The output is rxd_s, and the FSM uses only rxd_s.
- Counters:
  - cnt: 13 bits, counts 0..CLKS_PER_BIT-1.
  - bitidx: 3 bits.
  - shreg: 8 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
- IDLE:
  - cnt=0.
  - rxd_s==0 → START, with cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1: if rxd_s==0 → DATA, with cnt=0 and bitidx=0. Otherwise the low was a glitch → IDLE, with no outputs.
- DATA:
  - At cnt==CLKS_PER_BIT-1: shreg <= {rxd_s, shreg[7:1]} (LSB arrives first), cnt=0, bitidx++.
  - When bitidx==7 at that point → STOP.
- STOP, at cnt==CLKS_PER_BIT-1:
  - rxd_s==1: rx_data <= shreg, LED <= shreg, rx_valid=1 for one cycle → IDLE.
  - rxd_s==0: rx_frame_err=1 for one cycle. rx_data and LED are unchanged → BREAK.
- BREAK: stays here until rxd_s==1 → IDLE. This prevents a held-low line from producing repeated frames.
- rx_valid and rx_frame_err are never high in the same cycle. Both are registered outputs.
- Because the stop bit is sampled at its mid-point, the block is back in IDLE at the stop-bit centre. This gives half a bit of slack before the next start edge, so back-to-back frames are received with no gap.
- Reset mid-frame: the FSM returns to IDLE at once and the partial byte is discarded. The first full frame after release is received correctly.

## Timing
- Reset values: rx_data=8'h00, LED=8'h00, rx_valid=0, rx_frame_err=0, synchroniser=1, state=IDLE.
- Let edge P be the first CLK_50M edge at which the pin is captured low. IDLE sees rxd_s low at edge P+1 and enters START at that edge; call it edge E.
- Sample instants are at edges E+HALF_BIT+k·CLKS_PER_BIT:
  - k=0: start-bit check.
  - k=1..8: data bits 0..7.
  - k=9: stop bit.
- rx_valid (or rx_frame_err) is high in the cycle following edge E+HALF_BIT+9·CLKS_PER_BIT. Nominal latency from the pin edge is 9.5 bit times plus 2 cycles.
- A low pulse shorter than HALF_BIT cycles produces no output.
- Frame period is 10·CLKS_PER_BIT = 52090 cycles. Sustained back-to-back input is accepted at exactly this rate.

## Test plan
- Reset: assert BTN_SOUTH asynchronously between clock edges → all outputs are zero immediately, and state is IDLE after release.
- Single frame carrying 0x41 at CLKS_PER_BIT=5209 → exactly one rx_valid pulse, rx_data=LED=0x41. The pulse lands within ±1 cycle of pin edge + 49488 cycles.
- 16 back-to-back frames 0x40..0x4F with no idle gap (the transmitter's pattern) → 16 rx_valid pulses, 52090 cycles apart, with data matching in order.
- Glitch: pin low for 1000 cycles, then high → no rx_valid, no rx_frame_err, FSM back in IDLE. A following 0x55 frame is received correctly.
- Framing error: frame 0xA5 with stop bit 0, line held low for 3 bit times, then high → one rx_frame_err pulse, rx_data unchanged, no further pulses while low. The next 0x3C frame is received correctly.
- Reset mid-frame: assert BTN_SOUTH during data bit 4 of frame 0xFF, release, then send 0x12 → no output for the aborted frame, rx_data=0x12.

Source files
------------

// File: rtl/rx_if.sv
// rx_if: received-byte bus of the RS232 receiver.
//   rx_data      [7:0] last byte received with a good stop bit
//   rx_valid           one-cycle pulse when rx_data updates
//   rx_frame_err       one-cycle pulse when the stop bit is sampled low
//   LED          [7:0] board LED mirror of rx_data
// master: the receiver drives the bus; slave: the consumer observes it.
interface rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] LED;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output LED
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err,
    input LED
  );
endinterface

// File: rtl/rx.sv
// rx: 8N1 serial receiver for the RS232 DCE port.
// Synchronises RXD, validates the start bit at its mid-point, samples the
// data bits LSB first and the stop bit at mid-period, and reports each frame
// as a valid pulse (good stop bit) or a frame-error pulse (stop bit low).
//   CLK_50M        clock, rising edge
//   BTN_SOUTH      asynchronous active-high reset
//   RS232_DCE_RXD  asynchronous serial input, idles high
//   rx_bus         rx_data / rx_valid / rx_frame_err / LED (rx_if.master)
module rx #(
  parameter int unsigned CLKS_PER_BIT = 5209,
  parameter int unsigned HALF_BIT     = 2604
) (
  input  logic CLK_50M,
  input  logic BTN_SOUTH,
  input  logic RS232_DCE_RXD,
  rx_if.master rx_bus
);

  localparam int unsigned CNT_W = 13;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic             sync1_q, sync2_q;
  logic             rxd_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bitidx_q, bitidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       led_q, led_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_frame_err_q, rx_frame_err_d;

  logic bit_end;
  logic half_end;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK_50M or posedge BTN_SOUTH) begin
    if (BTN_SOUTH) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RS232_DCE_RXD;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s    = sync2_q;
  assign bit_end  = (cnt_q == BIT_LAST);
  assign half_end = (cnt_q == HALF_LAST);

  // State register.
  always_ff @(posedge CLK_50M or posedge BTN_SOUTH) begin
    if (BTN_SOUTH) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rxd_s) state_d = START;
      START: if (half_end) state_d = rxd_s ? IDLE : DATA;
      DATA:  if (bit_end && (bitidx_q == IDX_LAST)) state_d = STOP;
      STOP:  if (bit_end) state_d = rxd_s ? IDLE : BREAK;
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; pulses default low every cycle.
  always_comb begin
    cnt_d          = cnt_q;
    bitidx_d       = bitidx_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    led_d          = led_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitidx_d = '0;
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (half_end) begin
          cnt_d    = '0;
          bitidx_d = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          // LSB arrives first, so shift in from the top.
          shreg_d  = {rxd_s, shreg_q[7:1]};
          cnt_d    = '0;
          bitidx_d = bitidx_q + IDX_W'(1);
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (rxd_s) begin
            rx_data_d  = shreg_q;
            led_d      = shreg_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_frame_err_d = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK_50M or posedge BTN_SOUTH) begin
    if (BTN_SOUTH) begin
      cnt_q          <= '0;
      bitidx_q       <= '0;
      shreg_q        <= '0;
      rx_data_q      <= '0;
      led_q          <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bitidx_q       <= bitidx_d;
      shreg_q        <= shreg_d;
      rx_data_q      <= rx_data_d;
      led_q          <= led_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign rx_bus.rx_data      = rx_data_q;
  assign rx_bus.LED          = led_q;
  assign rx_bus.rx_valid     = rx_valid_q;
  assign rx_bus.rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_rx.sv
// tb_rx: scoreboard bench for rx with a shortened bit period.
module tb_rx;
  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  rx_if bus ();

  rx #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF)
  ) dut (
    .CLK_50M      (clk),
    .BTN_SOUTH    (rst),
    .RS232_DCE_RXD(rxd),
    .rx_bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       q[$];
  int         ncmp = 0;
  int         nbad = 0;
  logic [7:0] last_good = 8'h00;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // All pin changes happen 2 time units after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive one 8N1 frame and queue the response it must produce. The pulse is
  // expected 9.5 bit times after the pin edge plus synchroniser delay.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    exp_t e;
    if (stop_ok) last_good = d;
    e.ferr = !stop_ok;
    e.data = last_good;
    e.at   = cyc + 3 + int'(HALF) + 9 * int'(CPB);
    q.push_back(e);
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_cyc(CPB);
    end
    rxd = stop_ok;
    wait_cyc(CPB);
    if (!stop_ok) begin
      rxd = 1'b0;
      wait_cyc(3 * CPB);
      rxd = 1'b1;
      wait_cyc(2 * CPB);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && (bus.rx_valid || bus.rx_frame_err)) begin
        if (q.size() == 0) begin
          ncmp++;
          nbad++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%0h at cycle %0d, want no pulse",
                   bus.rx_valid, bus.rx_frame_err, bus.rx_data, cyc);
        end else begin
          e = q.pop_front();
          chk("exclusive", 32'(bus.rx_valid & bus.rx_frame_err), 32'd0);
          chk("frame_err", 32'(bus.rx_frame_err), 32'(e.ferr));
          chk("rx_data", 32'(bus.rx_data), 32'(e.data));
          chk("LED", 32'(bus.LED), 32'(e.data));
          ncmp++;
          if (cyc < e.at - 1 || cyc > e.at + 1) begin
            nbad++;
            $display("FAIL latency: pulse at cycle %0d, want %0d +/-1", cyc, e.at);
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         ok;
    int         gap;

    fork
      monitor();
    join_none

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
    chk("reset_LED", 32'(bus.LED), 32'd0);
    chk("reset_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_ferr", 32'(bus.rx_frame_err), 32'd0);
    wait_cyc(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_cyc(CPB);

    send_frame(8'h41, 1'b1);
    wait_cyc(CPB);

    // Back-to-back frames, no idle gap.
    for (int k = 0; k < 16; k++) send_frame(8'(8'h40 + k), 1'b1);
    wait_cyc(CPB);

    // Short glitch must produce nothing.
    rxd = 1'b0;
    wait_cyc(HALF / 2);
    rxd = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(8'h55, 1'b1);
    wait_cyc(CPB);

    // Framing error with line held low, then a good frame.
    send_frame(8'hA5, 1'b0);
    send_frame(8'h3C, 1'b1);
    wait_cyc(CPB);

    // Reset during data bit 4 of 0xFF.
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      wait_cyc(CPB);
    end
    rxd = 1'b1;
    wait_cyc(CPB / 2);
    #1 rst = 1'b1;
    #1;
    chk("midreset_rx_data", 32'(bus.rx_data), 32'd0);
    chk("midreset_LED", 32'(bus.LED), 32'd0);
    chk("midreset_valid", 32'(bus.rx_valid), 32'd0);
    last_good = 8'h00;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(CPB);
    send_frame(8'h12, 1'b1);
    wait_cyc(CPB);

    // Random frames, gaps, glitches and framing errors.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        rxd = 1'b0;
        wait_cyc($urandom_range(1, HALF - 3));
        rxd = 1'b1;
        wait_cyc(CPB);
      end
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(d, ok);
      gap = int'($urandom_range(0, 2 * CPB));
      if (gap > 0) wait_cyc(gap);
    end

    // Every queued response must have appeared.
    for (int t = 0; t < 20 * int'(CPB) && q.size() != 0; t++) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    wait_cyc(2 * CPB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
